// File: rtl/interrupt_controller.sv
// interrupt_controller
//   Synchronises and edge-detects four asynchronous interrupt lines and keeps
//   per-source pending/overflow state. A software mask and fixed priority
//   (int1 highest) select one source. That source is presented to the PC
//   through a req/ack handshake and then held in service until reti retires,
//   so interrupts never nest.
//
//   Ports
//     clk, reset          system clock, async active-low reset
//     int_in[3:0]         raw async lines, bit0 = int1 (highest priority)
//     inhibit             PC is in ROM range; no new request is issued
//     mask_we/mask_wdata  mask register write (1 = source disabled)
//     status_clr[3:0]     per-bit clear of the sticky overflow flags
//     int_ack             PC took the request
//     reti_done           reti retired; leave service
//     int_req, int_id     registered request and its vector (1..4, 0 idle)
//     in_service          high from ack until reti_done
//     pending, overflow   latched edges / edge-while-pending flags
//     mask                current mask register

// Per-source synchroniser chain, history flop and rising-edge detector.
// SYNC_STAGES must be at least 2.
module int_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic line,
    output logic rise
);
    logic [SYNC_STAGES-1:0] sync;
    logic                   history;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync    <= '0;
            history <= 1'b0;
        end else begin
            sync    <= {sync[SYNC_STAGES-2:0], line};
            history <= sync[SYNC_STAGES-1];
        end
    end

    assign rise = sync[SYNC_STAGES-1] & ~history;
endmodule

module interrupt_controller #(
    parameter int NSRC        = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] int_in,
    input  logic            inhibit,
    input  logic            mask_we,
    input  logic [NSRC-1:0] mask_wdata,
    input  logic [NSRC-1:0] status_clr,
    input  logic            int_ack,
    input  logic            reti_done,
    output logic            int_req,
    output logic [2:0]      int_id,
    output logic            in_service,
    output logic [NSRC-1:0] pending,
    output logic [NSRC-1:0] overflow,
    output logic [NSRC-1:0] mask
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_SERVICE} state_t;

    state_t              state, state_next;
    logic [2:0]          id_next, win_id;
    logic [NSRC-1:0]     rise, edge_v, eligible, ack_clr;
    logic [SYNC_STAGES:0] arm_pipe;
    logic                take;

    for (genvar g = 0; g < NSRC; g++) begin : g_src
        int_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_edge (
            .clk   (clk),
            .reset (reset),
            .line  (int_in[g]),
            .rise  (rise[g])
        );
    end

    // After reset the sync/history flops start at 0, so a line already high
    // would look like a rising edge once it reaches the last stage. Edges are
    // ignored until the chain and history have been refilled from the pins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) arm_pipe <= '0;
        else        arm_pipe <= {arm_pipe[SYNC_STAGES-1:0], 1'b1};
    end

    assign edge_v   = rise & {NSRC{arm_pipe[SYNC_STAGES]}};
    assign eligible = pending & ~mask;
    assign take     = (state == S_REQ) && int_ack;

    // Fixed priority: lowest set bit wins.
    always_comb begin
        win_id = '0;
        for (int i = NSRC - 1; i >= 0; i--)
            if (eligible[i]) win_id = 3'(i + 1);
    end

    always_comb begin
        ack_clr = '0;
        for (int i = 0; i < NSRC; i++)
            ack_clr[i] = take && (int_id == 3'(i + 1));
    end

    always_comb begin
        state_next = state;
        id_next    = int_id;
        case (state)
            S_IDLE: begin
                if (eligible != '0 && !inhibit) begin
                    state_next = S_REQ;
                    id_next    = win_id;
                end
            end
            S_REQ: begin
                if (int_ack) begin
                    state_next = S_SERVICE;
                    id_next    = '0;
                end
            end
            S_SERVICE: begin
                if (reti_done) state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
                id_next    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            int_id <= '0;
        end else begin
            state  <= state_next;
            int_id <= id_next;
        end
    end

    // A new edge wins over the ack clear, and an edge landing in the same
    // cycle as the ack is treated as a fresh request rather than an overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending  <= '0;
            overflow <= '0;
            mask     <= '0;
        end else begin
            pending  <= (pending & ~ack_clr) | edge_v;
            overflow <= (overflow & ~status_clr) | (edge_v & pending & ~ack_clr);
            if (mask_we) mask <= mask_wdata;
        end
    end

    assign int_req    = (state == S_REQ);
    assign in_service = (state == S_SERVICE);
endmodule

// File: tb/tb_interrupt_controller.sv
// Bench for interrupt_controller: directed vectors with literal checks, plus a
// sample-history reference model compared against all outputs every cycle.
module tb_interrupt_controller;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] int_in = '0;
    logic       inhibit = 1'b0;
    logic       mask_we = 1'b0;
    logic [3:0] mask_wdata = '0;
    logic [3:0] status_clr = '0;
    logic       int_ack = 1'b0;
    logic       reti_done = 1'b0;
    logic       int_req;
    logic [2:0] int_id;
    logic       in_service;
    logic [3:0] pending;
    logic [3:0] overflow;
    logic [3:0] mask;

    int checks = 0;
    int errors = 0;

    interrupt_controller #(.NSRC(4), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .int_in     (int_in),
        .inhibit    (inhibit),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .status_clr (status_clr),
        .int_ack    (int_ack),
        .reti_done  (reti_done),
        .int_req    (int_req),
        .int_id     (int_id),
        .in_service (in_service),
        .pending    (pending),
        .overflow   (overflow),
        .mask       (mask)
    );

    always #5 clk = ~clk;

    logic [16:0] dut_v;
    assign dut_v = {int_req, int_id, in_service, pending, overflow, mask};

    // Reference model: an edge is visible to pending two clocks after the pin
    // sample that shows it high (previous sample low); edges are ignored for
    // the first three clocks after reset.
    localparam int PH_IDLE = 0, PH_REQ = 1, PH_SVC = 2;
    int         m_phase = PH_IDLE;
    int         nedge = 0;
    logic [3:0] m_pend = '0, m_ovf = '0, m_mask = '0;
    logic [2:0] m_id = '0;
    logic [3:0] samp [3];
    logic [3:0] rising, elig, low, clr;

    initial begin
        for (int i = 0; i < 3; i++) samp[i] = '0;
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                m_phase = PH_IDLE; nedge = 0;
                m_pend = '0; m_ovf = '0; m_mask = '0; m_id = '0;
                for (int i = 0; i < 3; i++) samp[i] = '0;
            end else begin
                nedge++;
                rising = (nedge >= 4) ? (samp[1] & ~samp[2]) : 4'b0;
                samp[2] = samp[1]; samp[1] = samp[0]; samp[0] = int_in;
                elig = m_pend & ~m_mask;
                clr = '0;
                if (m_phase == PH_REQ && int_ack) clr = 4'(1 << (m_id - 3'd1));
                m_ovf  = (m_ovf & ~status_clr) | (rising & m_pend & ~clr);
                m_pend = (m_pend & ~clr) | rising;
                if (m_phase == PH_IDLE) begin
                    if (elig != 0 && !inhibit) begin
                        low = elig & (~elig + 4'd1);
                        m_id = 3'($clog2(low) + 1);
                        m_phase = PH_REQ;
                    end
                end else if (m_phase == PH_REQ) begin
                    if (int_ack) begin
                        m_id = '0;
                        m_phase = PH_SVC;
                    end
                end else if (reti_done) begin
                    m_phase = PH_IDLE;
                end
                if (mask_we) m_mask = mask_wdata;
            end
        end
    end

    logic [16:0] mdl_v;
    assign mdl_v = {m_phase == PH_REQ, m_id, m_phase == PH_SVC, m_pend, m_ovf, m_mask};

    initial begin
        forever begin
            @(negedge clk);
            #1;
            checks++;
            if (dut_v !== mdl_v) begin
                errors++;
                $display("FAIL model_cmp t=%0t got req=%b id=%0d svc=%b pend=%b ovf=%b mask=%b want req=%b id=%0d svc=%b pend=%b ovf=%b mask=%b",
                         $time, dut_v[16], dut_v[15:13], dut_v[12], dut_v[11:8], dut_v[7:4], dut_v[3:0],
                         mdl_v[16], mdl_v[15:13], mdl_v[12], mdl_v[11:8], mdl_v[7:4], mdl_v[3:0]);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_ack;
        int_ack = 1'b1; cyc(); int_ack = 1'b0;
    endtask

    task automatic pulse_reti;
        reti_done = 1'b1; cyc(); reti_done = 1'b0;
    endtask

    initial begin
        cyc(3);
        chk("reset_state", int'(dut_v), 0);
        reset = 1'b1;
        cyc(6);

        // Single source
        int_in = 4'b0001;
        cyc(3);
        chk("single_pending", int'(pending), 1);
        chk("single_req_early", int'(int_req), 0);
        cyc(1);
        chk("single_req", int'(int_req), 1);
        chk("single_id", int'(int_id), 1);
        cyc(1);
        int_in = 4'b0000;
        pulse_ack;
        chk("single_ack_pend", int'(pending), 0);
        chk("single_ack_svc", int'(in_service), 1);
        chk("single_ack_req", int'(int_req), 0);
        cyc(2);
        pulse_reti;
        chk("single_reti_svc", int'(in_service), 0);

        // Priority
        int_in = 4'b1010;
        cyc(4);
        chk("prio_first_id", int'(int_id), 2);
        int_in = 4'b0000;
        pulse_ack;
        cyc(1);
        pulse_reti;
        chk("prio_gap_req", int'(int_req), 0);
        cyc(1);
        chk("prio_second_id", int'(int_id), 4);
        pulse_ack;
        pulse_reti;

        // Mask and inhibit
        mask_we = 1'b1; mask_wdata = 4'b0001;
        cyc(1);
        mask_we = 1'b0;
        chk("mask_value", int'(mask), 1);
        int_in = 4'b0001;
        cyc(6);
        chk("mask_pending", int'(pending), 1);
        chk("mask_no_req", int'(int_req), 0);
        inhibit = 1'b1; mask_we = 1'b1; mask_wdata = 4'b0000;
        cyc(1);
        mask_we = 1'b0;
        cyc(2);
        chk("inhibit_no_req", int'(int_req), 0);
        inhibit = 1'b0;
        cyc(1);
        chk("uninhibit_req", int'(int_req), 1);
        chk("uninhibit_id", int'(int_id), 1);
        int_in = 4'b0000;
        pulse_ack;
        pulse_reti;

        // Overflow
        int_in = 4'b0100; cyc(2);
        int_in = 4'b0000; cyc(2);
        int_in = 4'b0100; cyc(2);
        int_in = 4'b0000; cyc(3);
        chk("ovf_set", int'(overflow), 4);
        chk("ovf_req_id", int'(int_id), 3);
        pulse_ack;
        chk("ovf_ack_pend", int'(pending), 0);
        chk("ovf_ack_keep", int'(overflow), 4);
        status_clr = 4'b0100; cyc(1); status_clr = 4'b0000;
        chk("ovf_clr", int'(overflow), 0);
        pulse_reti;

        // Edge colliding with ack of the same source
        int_in = 4'b0001; cyc(2);
        int_in = 4'b0000; cyc(3);
        chk("coll_req", int'(int_id), 1);
        int_in = 4'b0001; cyc(2);
        pulse_ack;
        chk("coll_pend", int'(pending), 1);
        chk("coll_ovf", int'(overflow), 0);
        chk("coll_svc", int'(in_service), 1);
        int_in = 4'b0000;
        pulse_reti;
        cyc(1);
        chk("coll_rereq", int'(int_req), 1);
        chk("coll_rereq_id", int'(int_id), 1);
        pulse_ack;
        pulse_reti;

        // Async reset while in REQ
        int_in = 4'b0010; cyc(4);
        chk("rst_req_pre", int'(int_req), 1);
        #2 reset = 1'b0;
        #1 chk("rst_req_clear", int'(dut_v), 0);
        int_in = 4'b1111;
        cyc(2);
        reset = 1'b1;
        cyc(8);
        chk("rst_req_nohold", int'(int_req), 0);
        chk("rst_req_nopend", int'(pending), 0);

        // Async reset while in SERVICE
        int_in = 4'b0000; cyc(3);
        int_in = 4'b0100; cyc(4);
        chk("rst_svc_id", int'(int_id), 3);
        pulse_ack;
        chk("rst_svc_pre", int'(in_service), 1);
        #2 reset = 1'b0;
        #1 chk("rst_svc_clear", int'(dut_v), 0);
        int_in = 4'b1111;
        cyc(2);
        reset = 1'b1;
        cyc(8);
        chk("rst_svc_nohold", int'(int_req), 0);
        chk("rst_svc_nopend", int'(pending), 0);
        chk("rst_svc_noovf", int'(overflow), 0);

        cyc(1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/interrupt_controller.md
# interrupt_controller

Collects the four external interrupt lines, synchronises and edge-detects them, and holds per-source pending state. Applies a software mask and fixed priority, and presents one interrupt at a time to the program counter through a req/ack handshake. It tracks the in-service interrupt until the CPU executes `reti`, so nesting never occurs. The block sits between the I/O interrupt sources and the PC, and replaces raw int1..int4 wiring into the PC.

## Interface
- `NSRC`, 4: number of interrupt sources (fixed at 4; ids 1..4).
- `SYNC_STAGES`, 2: synchroniser flops per input before edge detection.

- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `int_in`  in  4  raw interrupt lines, asynchronous; bit0 = int1 (highest priority), bit3 = int4 (lowest).
- `inhibit`  in  1  high while PC is in the ROM range; blocks new requests.
- `mask_we`  in  1  write strobe for the mask register.
- `mask_wdata`  in  4  new mask value; bit = 1 disables that source.
- `status_clr`  in  4  per-bit pulse that clears the corresponding `overflow` bit.
- `int_ack`  in  1  one-cycle pulse from PC: request taken at a writeback boundary.
- `reti_done`  in  1  one-cycle pulse when a `reti` instruction retires.
- `int_req`  out  1  interrupt request to PC (registered).
- `int_id`  out  3  vector of requested interrupt, 1..4; 0 when idle (registered).
- `in_service`  out  1  high from ack until `reti_done`.
- `pending`  out  4  latched edges not yet acknowledged.
- `overflow`  out  4  sticky; an edge arrived while the same source was already pending.
- `mask`  out  4  current mask register.

## Operation
- Each `int_in` bit passes through `SYNC_STAGES` flops plus one history flop. A rising edge is sync_out & ~history.
- A detected edge sets `pending[i]`. If `pending[i]` is already 1, the edge sets `overflow[i]` instead.
- Masked sources still latch into `pending`; the mask only gates arbitration.
- Eligible set = `pending & ~mask`. Winner = lowest set bit. `int_id` = bit index + 1.
- FSM states: IDLE, REQ, SERVICE.
  - IDLE -> REQ when the eligible set is non-zero and `inhibit` = 0. On that edge, register `int_req` = 1 and `int_id` = winner.
  - REQ: `int_req` and `int_id` hold stable until `int_ack`. Mask writes, `inhibit` and new edges during REQ do not change them.
  - REQ + `int_ack` -> SERVICE. Clear `pending[int_id-1]`, drop `int_req`, set `int_id` = 0 and `in_service` = 1.
  - SERVICE + `reti_done` -> IDLE and drop `in_service`. A new request can be issued on the following edge.
- `int_ack` outside REQ and `reti_done` outside SERVICE are ignored.
- Simultaneous events:
  - Ack clearing `pending[i]` in the same cycle as a new edge on source i leaves `pending[i]` = 1, with no overflow.
  - `status_clr[i]` in the same cycle as an overflow-setting edge leaves `overflow[i]` = 1 (set wins).
  - A mask write takes effect for arbitration on the cycle after the write.
- Reset (async, any state): FSM to IDLE. `int_req` = 0, `int_id` = 0, `in_service` = 0, `pending` = 0, `overflow` = 0, `mask` = 0 (all enabled), synchroniser and history flops = 0. A line held high through reset release produces no edge.

## Timing
- Input rising between edges k-1 and k reaches sync stage 2 at edge k+1. `pending` sets at edge k+2 and `int_req` rises at edge k+3. Worst-case latency from pin to request is 3 cycles plus the sampling uncertainty.
- Ack-to-`int_req` low: 1 cycle. `reti_done` to the next possible `int_req`: 2 edges (SERVICE -> IDLE -> REQ).
- All outputs are registered; no combinational path from input to output.
- Pulse inputs (`int_ack`, `reti_done`, `mask_we`, `status_clr`) are sampled on a single edge. Holding them for more than one cycle is a protocol error; extra cycles are ignored per the state rules.

## Test plan
- Single source: raise `int_in`=4'b0001, hold 5 cycles. Expect `pending`=0001, then `int_req`=1 and `int_id`=1 exactly 3 edges after the sync edge. Ack gives `pending`=0000 and `in_service`=1. `reti_done` gives `in_service`=0.
- Priority: raise `int_in`=4'b1010 in the same cycle. Expect `int_id`=2 first. After ack and `reti_done`, expect `int_id`=4 two edges later.
- Mask and inhibit: `mask`=4'b0001 with an edge on int1 gives `pending`=0001 and no `int_req`. Writing `mask`=0 while `inhibit`=1 gives no request. Dropping `inhibit` gives `int_req` on the next edge.
- Overflow: two int3 edges before ack give `overflow`=0100. Ack clears pending but `overflow` stays 0100. `status_clr`=0100 gives 0000.
- Edge/ack collision: an int1 edge synchronised to the same cycle as ack of int1 leaves `pending[0]`=1 and `overflow[0]`=0. After `reti_done` a second request arrives with `int_id`=1.
- Async reset in REQ and in SERVICE: assert `reset`=0 mid-cycle. All outputs clear immediately without a clock. Release with `int_in`=1111 held produces no request.
